// File: rtl/alu_rr_scheduler_pkg.sv
// Shared ALU instruction format plus scheduler state encoding.
// Reused by the round-robin scheduler and anything else that drives the ALU IW port.
package alu_rr_scheduler_pkg;

  localparam int ALU_W         = 32;
  localparam int SCHED_MAX_REQ = 8;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL,
    OP_SHR,
    OP_PASS
  } opcode_t;

  typedef struct packed {
    opcode_t            opcode;
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response/ALU bundle between the issuers (master) and the shared-ALU scheduler (slave).
// Requests use valid/ready; responses are held until the granted requester's rsp_ready.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import alu_rr_scheduler_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  instruction_t [NUM_REQ-1:0] req_inst;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ-1:0]         rsp_ready;
  logic [DATA_W-1:0]          rsp_result;
  instruction_t               alu_iw;
  logic [DATA_W-1:0]          alu_result;
  logic [ID_W-1:0]            grant_id;
  logic                       busy;

  modport master (
    output req_valid, req_inst, rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_result, alu_iw, grant_id, busy
  );

  modport slave (
    input  req_valid, req_inst, rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_result, alu_iw, grant_id, busy
  );

endinterface

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant (with wrap) wins.
// Zero latency; no state, so the caller owns last_grant and decides when a grant is taken.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    // Offset N wraps back onto last_grant itself, so a lone requester can win again.
    for (int off = 1; off <= N; off++) begin
      idx = IDW'((int'(last_grant) + off) % N);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NUM_REQ requesters in round-robin order; accept-to-rsp_valid is ALU_LATENCY+1 edges.
// Responses stall in RESP until the granted rsp_ready; ALU_SCHED_STATS_EN adds op_count/stall_cycles.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int DATA_W      = 32,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  alu_rr_scheduler_if.slave        bus
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] op_count,
  output logic [15:0]              stall_cycles
`endif
);

  localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  if (NUM_REQ < 2 || NUM_REQ > SCHED_MAX_REQ) begin : g_bad_num_req
    $error("alu_rr_scheduler: NUM_REQ must be 2..SCHED_MAX_REQ");
  end

  sched_state_t       state_q, state_d;
  instruction_t       alu_iw_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_vld;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               accept;
  logic               capture;
  logic               rsp_hs;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .gnt_id     (arb_id),
    .gnt_vld    (arb_vld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = arb_gnt;
        if (arb_vld) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Only the granted requester's rsp_ready matters; the rest are don't-care.
        if (bus.rsp_ready[grant_q]) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_iw_q     <= '0;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= '0;
    end else begin
      if (accept) begin
        alu_iw_q     <= bus.req_inst[arb_id];
        grant_q      <= arb_id;
        last_grant_q <= arb_id;
        cnt_q        <= CNT_W'(ALU_LATENCY);
      end
      if (state_q == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        rsp_result_q <= bus.alu_result;
        rsp_valid_q  <= NUM_REQ'(1) << grant_q;
      end
      if (rsp_hs) begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.alu_iw     = alu_iw_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q != IDLE);

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count     <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_hs && grant_q == ID_W'(i) && op_count[i] != 16'hFFFF) begin
          op_count[i] <= op_count[i] + 16'd1;
        end
      end
      if (state_q == RESP && !bus.rsp_ready[grant_q] && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a scoreboard of expected responses and behavioural ALUs.
module tb_alu_rr_scheduler;
  import alu_rr_scheduler_pkg::*;

  localparam int N = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];
  exp_t e_mon;
  exp_t e3;

  alu_rr_scheduler_if #(.NUM_REQ(N), .DATA_W(32)) b1 ();
  alu_rr_scheduler_if #(.NUM_REQ(N), .DATA_W(32)) b3 ();

`ifdef ALU_SCHED_STATS_EN
  logic [N-1:0][15:0] op_count1, op_count3;
  logic [15:0]        stall1, stall3;
`endif

  alu_rr_scheduler #(.NUM_REQ(N), .ALU_LATENCY(1), .DATA_W(32)) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (b1)
`ifdef ALU_SCHED_STATS_EN
    ,
    .op_count     (op_count1),
    .stall_cycles (stall1)
`endif
  );

  alu_rr_scheduler #(.NUM_REQ(N), .ALU_LATENCY(3), .DATA_W(32)) u_dut3 (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (b3)
`ifdef ALU_SCHED_STATS_EN
    ,
    .op_count     (op_count3),
    .stall_cycles (stall3)
`endif
  );

  function automatic logic [31:0] alu_ref(instruction_t iw);
    case (iw.opcode)
      OP_ADD:  return iw.a + iw.b;
      OP_SUB:  return iw.a - iw.b;
      OP_AND:  return iw.a & iw.b;
      OP_OR:   return iw.a | iw.b;
      OP_XOR:  return iw.a ^ iw.b;
      OP_SHL:  return iw.a << iw.b[4:0];
      OP_SHR:  return iw.a >> iw.b[4:0];
      default: return iw.a;
    endcase
  endfunction

  function automatic instruction_t mk(opcode_t op, logic [31:0] a, logic [31:0] b);
    instruction_t r;
    r.opcode = op;
    r.a      = a;
    r.b      = b;
    return r;
  endfunction

  // ALU models: result valid ALU_LATENCY edges after alu_iw changes.
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clock) begin
    pipe1    <= alu_ref(b1.alu_iw);
    pipe3[0] <= alu_ref(b3.alu_iw);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b1.alu_result = pipe1;
  assign b3.alu_result = pipe3[2];

  task automatic check(string tag, logic [79:0] obs, logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp1(output int n);
    n = 0;
    @(negedge clock);
    while (b1.rsp_valid == '0 && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
  endtask

  task automatic wait_rsp3(output int n);
    n = 0;
    @(negedge clock);
    while (b3.rsp_valid == '0 && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
  endtask

  // Response monitor for the latency-1 instance.
  always @(negedge clock) begin
    if (reset_n && ((b1.rsp_valid & b1.rsp_ready) != '0)) begin
      if (sb1.size() == 0) begin
        check("sb_unexpected_rsp", 80'(b1.rsp_valid), 80'd0);
      end else begin
        e_mon = sb1.pop_front();
        check("sb_rsp_id", 80'(b1.rsp_valid), 80'(1) << e_mon.id);
        check("sb_grant_id", 80'(b1.grant_id), 80'(e_mon.id));
        check("sb_result", 80'(b1.rsp_result), 80'(e_mon.res));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    b1.req_valid  = '0;
    b1.req_inst   = '0;
    b1.rsp_ready  = '1;
    b3.req_valid  = '0;
    b3.req_inst   = '0;
    b3.rsp_ready  = '1;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 80'(b1.busy), 80'd0);
    check("rst_rsp_valid", 80'(b1.rsp_valid), 80'd0);
    check("rst_grant_id", 80'(b1.grant_id), 80'd0);
    check("rst_alu_iw", 80'(b1.alu_iw), 80'd0);
    check("rst_rsp_result", 80'(b1.rsp_result), 80'd0);
    check("rst_req_ready", 80'(b1.req_ready), 80'd0);
    reset_n = 1'b1;
    tick();

    // Single ADD from requester 0
    b1.req_inst[0] = mk(OP_ADD, 10, 15);
    b1.req_valid   = 4'b0001;
    sb1.push_back('{0, 32'd25});
    @(negedge clock);
    check("t1_req_ready", 80'(b1.req_ready), 80'b0001);
    check("t1_busy_idle", 80'(b1.busy), 80'd0);
    @(posedge clock);
    #1;
    b1.req_valid = '0;
    check("t1_alu_iw", 80'(b1.alu_iw), 80'(mk(OP_ADD, 10, 15)));
    check("t1_busy_exec", 80'(b1.busy), 80'd1);
    wait_rsp1(n);
    check("t1_latency", 80'(n), 80'd2);
    check("t1_rsp_valid", 80'(b1.rsp_valid), 80'b0001);
    check("t1_rsp_result", 80'(b1.rsp_result), 80'd25);
    tick();
    tick();

    // SUB from requester 2 with backpressure; requester 1 waits
    b1.rsp_ready   = 4'b1011;
    b1.req_inst[2] = mk(OP_SUB, 20, 5);
    b1.req_valid   = 4'b0100;
    sb1.push_back('{2, 32'd15});
    @(negedge clock);
    check("t2_req_ready", 80'(b1.req_ready), 80'b0100);
    @(posedge clock);
    #1;
    b1.req_inst[1] = mk(OP_ADD, 100, 1);
    b1.req_valid   = 4'b0010;
    sb1.push_back('{1, 32'd101});
    wait_rsp1(n);
    check("t2_latency", 80'(n), 80'd2);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 80'(b1.rsp_valid), 80'b0100);
      check("t2_hold_result", 80'(b1.rsp_result), 80'd15);
      check("t2_hold_busy", 80'(b1.busy), 80'd1);
      check("t2_hold_no_ready", 80'(b1.req_ready), 80'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    b1.rsp_ready = '1;
    @(negedge clock);
    check("t2_no_accept_in_resp", 80'(b1.req_ready), 80'd0);
    @(posedge clock);
    @(negedge clock);
    check("t2_next_ready", 80'(b1.req_ready), 80'b0010);
    check("t2_idle_busy", 80'(b1.busy), 80'd0);
    @(posedge clock);
    #1;
    b1.req_valid = '0;
    check("t2_grant_id", 80'(b1.grant_id), 80'd1);
    wait_rsp1(n);
    check("t2_latency2", 80'(n), 80'd2);
    tick();
    tick();

    // Reset asserted during EXEC drops the transaction
    b1.req_inst[0] = mk(OP_ADD, 1, 2);
    b1.req_valid   = 4'b0001;
    @(posedge clock);
    #1;
    b1.req_valid = '0;
    check("t4_busy_exec", 80'(b1.busy), 80'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_busy", 80'(b1.busy), 80'd0);
    check("t4_rsp_valid", 80'(b1.rsp_valid), 80'd0);
    check("t4_grant_id", 80'(b1.grant_id), 80'd0);
    check("t4_alu_iw", 80'(b1.alu_iw), 80'd0);
    check("t4_rsp_result", 80'(b1.rsp_result), 80'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t4_no_rsp", 80'(b1.rsp_valid), 80'd0);
    end
    tick();
    b1.req_inst[3] = mk(OP_ADD, 40, 2);
    b1.req_valid   = 4'b1000;
    sb1.push_back('{3, 32'd42});
    @(negedge clock);
    check("t4_req_ready", 80'(b1.req_ready), 80'b1000);
    @(posedge clock);
    #1;
    b1.req_valid = '0;
    wait_rsp1(n);
    check("t4_latency", 80'(n), 80'd2);
    check("t4_grant3", 80'(b1.grant_id), 80'd3);
    tick();
    tick();

    // All requesters continuously valid: strict rotation
    for (int i = 0; i < N; i++) begin
      b1.req_inst[i] = mk(OP_ADD, 32'(i), 1);
    end
    b1.req_valid = '1;
    sb1.push_back('{0, 32'd1});
    sb1.push_back('{1, 32'd2});
    sb1.push_back('{2, 32'd3});
    sb1.push_back('{3, 32'd4});
    sb1.push_back('{0, 32'd1});
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      @(negedge clock);
      while (b1.req_ready == '0 && cyc < 20) begin
        @(negedge clock);
        cyc++;
      end
      check($sformatf("t3_grant%0d", k), 80'(b1.req_ready), 80'b0001 << (k % N));
      if (k > 0) check($sformatf("t3_period%0d", k), 80'(cyc), 80'd3);
      @(posedge clock);
      #1;
      if (k == 4) b1.req_valid = '0;
    end
    wait_rsp1(n);
    tick();
    tick();
    check("t3_sb_empty", 80'(sb1.size()), 80'd0);

    // Latency-3 instance
    b3.rsp_ready   = '0;
    b3.req_inst[0] = mk(OP_ADD, 7, 8);
    b3.req_valid   = 4'b0001;
    sb3.push_back('{0, 32'd15});
    @(negedge clock);
    check("t5_req_ready", 80'(b3.req_ready), 80'b0001);
    @(posedge clock);
    #1;
    b3.req_valid = '0;
    wait_rsp3(n);
    check("t5_latency", 80'(n), 80'd4);
    e3 = sb3.pop_front();
    check("t5_rsp_valid", 80'(b3.rsp_valid), 80'(1) << e3.id);
    check("t5_rsp_result", 80'(b3.rsp_result), 80'(e3.res));
    check("t5_grant_id", 80'(b3.grant_id), 80'(e3.id));
    tick();
    b3.rsp_ready = '1;
    tick();
    tick();
    check("t5_idle", 80'(b3.busy), 80'd0);

`ifdef ALU_SCHED_STATS_EN
    reset_n = 1'b0;
    #1;
    check("st_rst_op_count", 80'(op_count1), 80'd0);
    check("st_rst_stall", 80'(stall1), 80'd0);
    tick();
    reset_n = 1'b1;
    tick();
    b1.rsp_ready = 4'b1101;
    for (int t = 0; t < 3; t++) begin
      b1.req_inst[1] = mk(OP_ADD, 32'(t), 32'(t));
      b1.req_valid   = 4'b0010;
      sb1.push_back('{1, 32'(2 * t)});
      @(posedge clock);
      #1;
      b1.req_valid = '0;
      wait_rsp1(n);
      @(posedge clock);
      @(posedge clock);
      #1;
      b1.rsp_ready = '1;
      @(posedge clock);
      #1;
      b1.rsp_ready = 4'b1101;
      tick();
    end
    check("st_op_count1", 80'(op_count1[1]), 80'd3);
    check("st_op_count0", 80'(op_count1[0]), 80'd0);
    check("st_stall", 80'(stall1), 80'd6);
    b1.rsp_ready = '1;
    tick();
`endif

    check("final_sb1_empty", 80'(sb1.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one ALU (ALU_specific_item / ALU_wildcard / ALU_unit_space / ALU_explicit) between NUM_REQ requesters.
- Accepts one instruction_t per transaction through a valid/ready handshake and drives the ALU IW input.
- Waits out the fixed ALU pipeline latency, captures the ALU result, and returns it to the granted requester through a response handshake.
- Sits between the testbench/issue logic and the ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ALU_LATENCY, 1, clock edges from IW change to valid ALU result (1..4)
DATA_W, 32, ALU operand/result width
ID_W, $clog2(NUM_REQ), grant index width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester instruction valid
req_ready  output  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_inst  input  instruction_t [NUM_REQ]  per-requester instruction (opcode, a, b)
rsp_valid  output  NUM_REQ  per-requester result valid (one-hot or zero)
rsp_ready  input  NUM_REQ  per-requester result consumed
rsp_result  output  DATA_W  result for the requester flagged in rsp_valid
alu_iw  output  instruction_t  instruction word to the ALU IW port
alu_result  input  DATA_W  ALU result port
grant_id  output  ID_W  index of current/last granted requester
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - alu_iw = '0, rsp_result = 0, rsp_valid = 0, grant_id = 0, busy = 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-transaction: the transaction is dropped and no response is issued; the next transaction starts cleanly from IDLE.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from last_grant+1 upward with wrap modulo NUM_REQ.
  - req_ready[winner] = 1, combinational from req_valid; all other req_ready bits = 0. req_ready is never asserted outside IDLE.
  - On an edge with req_valid[w] & req_ready[w]: alu_iw <= req_inst[w]; grant_id <= w; last_grant <= w; cnt <= ALU_LATENCY; go to EXEC.
  - No req_valid: stay in IDLE; alu_iw holds its last value.
- EXEC:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: rsp_result <= alu_result; go to RESP.
  - EXEC lasts ALU_LATENCY+1 cycles. rsp_valid rises ALU_LATENCY+1 edges after the accept edge (2 for the default latency).
- RESP:
  - rsp_valid[grant_id] = 1, registered; rsp_result is held stable.
  - On rsp_ready[grant_id] = 1: clear rsp_valid; go to IDLE.
  - rsp_ready low: stay in RESP indefinitely; no new grant is issued.
  - rsp_ready bits of other requesters are ignored.
- A new request is never accepted in the same cycle as a response handshake; earliest re-accept is the next cycle. Minimum period is ALU_LATENCY+3 cycles per operation.
- Arithmetic: the scheduler does no arithmetic on operands. rsp_result is alu_result truncated/zero-extended to DATA_W.
- Fairness: continuously requesting clients are served in strict rotation. A requester waits at most NUM_REQ-1 transactions.

Optional Feature:
ALU_SCHED_STATS_EN
- Defined:
  - Adds output op_count[NUM_REQ][16]: per-requester completed-transaction counters. Each increments on its rsp handshake and saturates at 16'hFFFF.
  - Adds output stall_cycles[16]: counts cycles in RESP with rsp_ready low, saturating.
  - Both reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package definitions:
  - instruction_t and opcode enum (ADD, SUB, ...) are reused from it.
  - Add sched_state_t enum {IDLE, EXEC, RESP} and the constant SCHED_MAX_REQ = 8.
- Sub-module rr_arbiter (combinational): inputs req vector and last_grant; outputs one-hot grant and encoded index. Reusable for other shared resources.

Test Plan:
- Reset then single ADD from requester 0 (a=10, b=15) -> req_ready[0] in the first cycle; rsp_valid[0] 2 edges after accept; rsp_result=25; grant_id=0.
- SUB from requester 2 (a=20, b=5) with rsp_ready held low for 5 cycles -> rsp_valid[2] and rsp_result=15 stay stable; busy=1 throughout; req_valid[1] asserted meanwhile gets no req_ready.
- All 4 requesters valid continuously (ADD a=i, b=1) -> grant order 0,1,2,3,0; results 1,2,3,4,1.
- reset_n pulsed low during EXEC -> outputs zero immediately (asynchronous); no rsp_valid; next request from requester 3 is served normally with the correct result.
- ALU_LATENCY=3 build, ADD a=7, b=8 -> rsp_valid 4 edges after accept; rsp_result=15.
- With ALU_SCHED_STATS_EN: 3 transactions on requester 1 with 2 cycles of backpressure each -> op_count[1]=3, stall_cycles=6.
